mult_datapath: RTL and testbench

- Shift-add multiplier datapath driven by the multiplier control FSM's Load/Ad/Sh strobes.
- Returns M (current multiplier LSB) and K (last shift) to the FSM.
- Holds Mcand, a combined accumulator/multiplier register ACC, and a shift counter.
- Unsigned N x N -> 2N product, one bit per Add/Shift iteration pair.

---
 rtl/mult_datapath_if.sv | 46 ++++
 rtl/mult_datapath.sv | 86 ++++++++
 tb/tb_mult_datapath.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Strobe/operand/result bundle between the multiplier control FSM and the
// shift-add datapath. Optional PRODUCT_HOLD_EN adds the Valid result flag.
//
// Handshake: there is no valid/ready pair here. Load, Ad and Sh are level
// strobes sampled on every rising Clk edge. The datapath is always ready.
// M and K are combinational status from the datapath registers and are
// valid between edges.
interface mult_datapath_if #(
  parameter int N = 8
);
  logic           Load;
  logic           Ad;
  logic           Sh;
  logic [N-1:0]   Mcand_in;
  logic [N-1:0]   Mplier_in;
  logic           M;
  logic           K;
  logic [2*N-1:0] Product;
`ifdef PRODUCT_HOLD_EN
  logic           Valid;

  // Control side (FSM or bench) drives strobes and operands
  modport master (
    output Load, Ad, Sh, Mcand_in, Mplier_in,
    input  M, K, Product, Valid
  );

  // Datapath side
  modport slave (
    input  Load, Ad, Sh, Mcand_in, Mplier_in,
    output M, K, Product, Valid
  );
`else
  // Control side (FSM or bench) drives strobes and operands
  modport master (
    output Load, Ad, Sh, Mcand_in, Mplier_in,
    input  M, K, Product
  );

  // Datapath side
  modport slave (
    input  Load, Ad, Sh, Mcand_in, Mplier_in,
    output M, K, Product
  );
`endif
endinterface

// File: rtl/mult_datapath.sv
// Shift-add unsigned N x N -> 2N multiplier datapath.
// ACC is 2N+1 bits: the upper N+1 bits accumulate partial sums (with carry),
// the lower N bits start as the multiplier and shift out one bit per Sh.
// Optional macro PRODUCT_HOLD_EN: Product comes from a register captured on
// the final shift and a Valid flag is provided; otherwise Product is the
// live ACC[2N-1:0].
module mult_datapath #(
  parameter int N = 8
) (
  input logic            Clk,
  input logic            Rst,
  mult_datapath_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [2*N:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [CW-1:0] count_q, count_d;
  logic [N:0]    sum;
  logic          last_shift;

  // Upper-half add keeps its carry in the extra top bit
  assign sum        = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};
  assign last_shift = (count_q == CW'(N - 1));

  // Next-state selection: Load dominates, then Ad/Sh combinations
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    count_d = count_q;
    if (bus.Load) begin
      mcand_d = bus.Mcand_in;
      acc_d   = {{(N + 1){1'b0}}, bus.Mplier_in};
      count_d = '0;
    end else if (bus.Ad && !bus.Sh) begin
      acc_d = {sum, acc_q[N-1:0]};
    end else if (bus.Sh && !bus.Ad) begin
      acc_d   = {1'b0, acc_q[2*N:1]};
      count_d = last_shift ? '0 : count_q + CW'(1);
    end else if (bus.Ad && bus.Sh) begin
      acc_d   = {1'b0, sum, acc_q[N-1:1]};
      count_d = last_shift ? '0 : count_q + CW'(1);
    end
  end

  // Datapath registers with asynchronous clear
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  assign bus.M = acc_q[0];
  assign bus.K = last_shift;

`ifdef PRODUCT_HOLD_EN
  logic [2*N-1:0] prod_q;
  logic           valid_q;

  // Result capture on the final shift; Valid cleared when a new Load starts
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.Load) begin
      valid_q <= 1'b0;
    end else if (bus.Sh && last_shift) begin
      prod_q  <= acc_d[2*N-1:0];
      valid_q <= 1'b1;
    end
  end

  assign bus.Product = prod_q;
  assign bus.Valid   = valid_q;
`else
  assign bus.Product = acc_q[2*N-1:0];
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath (N=8). Build with +define+PRODUCT_HOLD_EN
// to exercise the held-product variant.
module tb_mult_datapath;

  localparam int N = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  // Clock
  always #5 Clk = ~Clk;

  mult_datapath_if #(.N(N)) bus ();

  mult_datapath #(.N(N)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [2*N-1:0] held_exp  = '0;
  logic           valid_exp = 1'b0;

  // Reference: ACC contents after i shifts of a*b by shift-add multiplication.
  // Upper part holds a*(low i bits of b) aligned to bit N-i, lower part b>>i.
  function automatic logic [2*N-1:0] live_val(input int unsigned a, input int unsigned b,
                                               input int i);
    longint unsigned la, lb, low, p;
    la  = longint'(a);
    lb  = longint'(b);
    low = lb & ((64'd1 << i) - 64'd1);
    p   = ((la * low) << (N - i)) + (lb >> i);
    return p[2*N-1:0];
  endfunction

  // What Product should show, given the live ACC value
  function automatic logic [2*N-1:0] exp_prod(input logic [2*N-1:0] live);
`ifdef PRODUCT_HOLD_EN
    return held_exp;
`else
    return live;
`endif
  endfunction

  // Driver: apply one set of strobes for exactly one rising edge
  task automatic step(input logic ld, input logic ad, input logic sh);
    @(negedge Clk);
    bus.Load = ld;
    bus.Ad   = ad;
    bus.Sh   = sh;
    @(posedge Clk);
    #1;
    bus.Load = 1'b0;
    bus.Ad   = 1'b0;
    bus.Sh   = 1'b0;
  endtask

  // FSM-style run: Load, then per bit an optional Ad followed by Sh (or a
  // combined Ad+Sh). iters < N leaves the operation in progress.
  task automatic run_mult(input int unsigned a, input int unsigned b, input bit comb,
                          input int iters);
    logic [2*N-1:0]  e;
    logic            bitv;
    longint unsigned t;
    bus.Mcand_in  = a[N-1:0];
    bus.Mplier_in = b[N-1:0];
    step(1'b1, 1'b0, 1'b0);
    valid_exp = 1'b0;
    e = exp_prod(live_val(a, b, 0));
    n_vec++;
    if (bus.Product !== e) begin
      n_err++;
      $display("FAIL load_product a=%0d b=%0d got %0d want %0d", a, b, bus.Product, e);
    end
    n_vec++;
    if (bus.K !== 1'b0) begin
      n_err++;
      $display("FAIL load_k a=%0d b=%0d got %b want 0", a, b, bus.K);
    end
`ifdef PRODUCT_HOLD_EN
    n_vec++;
    if (bus.Valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_valid a=%0d b=%0d got %b want 0", a, b, bus.Valid);
    end
`endif
    for (int i = 0; i < iters; i++) begin
      bitv = b[i];
      n_vec++;
      if (bus.M !== bitv) begin
        n_err++;
        $display("FAIL m_bit a=%0d b=%0d i=%0d got %b want %b", a, b, i, bus.M, bitv);
      end
      if (!comb && bitv) begin
        step(1'b0, 1'b1, 1'b0);
        t = longint'(live_val(a, b, i)) + (longint'(a) << N);
        e = exp_prod(t[2*N-1:0]);
        n_vec++;
        if (bus.Product !== e) begin
          n_err++;
          $display("FAIL add_product a=%0d b=%0d i=%0d got %0d want %0d", a, b, i, bus.Product, e);
        end
      end
      n_vec++;
      if (bus.K !== (i == N - 1)) begin
        n_err++;
        $display("FAIL k_at_shift a=%0d b=%0d i=%0d got %b want %b", a, b, i, bus.K, (i == N - 1));
      end
      step(1'b0, comb && bitv, 1'b1);
      if (i == N - 1) begin
        t         = longint'(a) * longint'(b);
        held_exp  = t[2*N-1:0];
        valid_exp = 1'b1;
      end
      e = exp_prod(live_val(a, b, i + 1));
      n_vec++;
      if (bus.Product !== e) begin
        n_err++;
        $display("FAIL shift_product a=%0d b=%0d i=%0d got %0d want %0d", a, b, i, bus.Product, e);
      end
    end
    if (iters == N) begin
      t = longint'(a) * longint'(b);
      n_vec++;
      if (bus.Product !== t[2*N-1:0]) begin
        n_err++;
        $display("FAIL final_product a=%0d b=%0d got %0d want %0d", a, b, bus.Product, t[2*N-1:0]);
      end
      n_vec++;
      if (bus.K !== 1'b0) begin
        n_err++;
        $display("FAIL k_after_final a=%0d b=%0d got %b want 0", a, b, bus.K);
      end
`ifdef PRODUCT_HOLD_EN
      n_vec++;
      if (bus.Valid !== 1'b1) begin
        n_err++;
        $display("FAIL final_valid a=%0d b=%0d got %b want 1", a, b, bus.Valid);
      end
`endif
    end
  endtask

  task automatic check_cleared(input string tag);
    n_vec++;
    if (bus.M !== 1'b0) begin
      n_err++;
      $display("FAIL %s_m got %b want 0", tag, bus.M);
    end
    n_vec++;
    if (bus.K !== 1'b0) begin
      n_err++;
      $display("FAIL %s_k got %b want 0", tag, bus.K);
    end
    n_vec++;
    if (bus.Product !== '0) begin
      n_err++;
      $display("FAIL %s_product got %0d want 0", tag, bus.Product);
    end
`ifdef PRODUCT_HOLD_EN
    n_vec++;
    if (bus.Valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_valid got %b want 0", tag, bus.Valid);
    end
`endif
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    held_exp  = '0;
    valid_exp = 1'b0;
    check_cleared("reset");
    Rst = 1'b0;
  endtask

  task automatic test_directed();
    run_mult(13, 11, 1'b0, N);
    run_mult(255, 255, 1'b0, N);
    run_mult(0, 255, 1'b0, N);
    run_mult(8'hA5, 0, 1'b0, N);
  endtask

  task automatic test_combined();
    run_mult(13, 11, 1'b1, N);
    run_mult(255, 255, 1'b1, N);
  endtask

  task automatic test_abort();
    run_mult(13, 11, 1'b0, 3);
    run_mult(7, 9, 1'b0, N);
  endtask

  task automatic test_async_reset();
    run_mult(13, 11, 1'b0, 3);
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    held_exp  = '0;
    valid_exp = 1'b0;
    check_cleared("async_reset");
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_shift_no_load();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (bus.K !== (i == N - 1)) begin
        n_err++;
        $display("FAIL noload_k i=%0d got %b want %b", i, bus.K, (i == N - 1));
      end
      step(1'b0, 1'b0, 1'b1);
      if (i == N - 1) begin
        held_exp  = '0;
        valid_exp = 1'b1;
      end
      n_vec++;
      if (bus.Product !== '0) begin
        n_err++;
        $display("FAIL noload_product i=%0d got %0d want 0", i, bus.Product);
      end
    end
    n_vec++;
    if (bus.K !== 1'b0) begin
      n_err++;
      $display("FAIL noload_k_wrap got %b want 0", bus.K);
    end
`ifdef PRODUCT_HOLD_EN
    n_vec++;
    if (bus.Valid !== valid_exp) begin
      n_err++;
      $display("FAIL noload_valid got %b want %b", bus.Valid, valid_exp);
    end
`endif
  endtask

  task automatic test_random();
    int unsigned a, b;
    for (int r = 0; r < 16; r++) begin
      a = $urandom_range(0, (1 << N) - 1);
      b = $urandom_range(0, (1 << N) - 1);
      run_mult(a, b, bit'($urandom_range(0, 1)), N);
    end
  endtask

`ifdef PRODUCT_HOLD_EN
  // Held result must survive a new Load and only change at its final shift
  task automatic test_hold();
    run_mult(13, 11, 1'b0, N);
    run_mult(7, 9, 1'b0, N);
  endtask
`endif

  initial begin
    bus.Load      = 1'b0;
    bus.Ad        = 1'b0;
    bus.Sh        = 1'b0;
    bus.Mcand_in  = '0;
    bus.Mplier_in = '0;
    test_reset();
    test_shift_no_load();
    test_reset();
    test_directed();
    test_combined();
    test_abort();
    test_async_reset();
`ifdef PRODUCT_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
